ps2_scancode_decoder: RTL and testbench

PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

---
 rtl/ps2_pkg.sv | 19 +
 rtl/ps2_evt_fifo.sv | 41 ++++
 rtl/ps2_scancode_decoder.sv | 103 ++++++++++
 tb/tb_ps2_scancode_decoder.sv | 115 +++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared parser states, PS/2 byte constants and the queued event format.
package ps2_pkg;
  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_t;
  localparam logic [7:0] B_E0 = 8'hE0;
  localparam logic [7:0] B_E1 = 8'hE1;
  localparam logic [7:0] B_F0 = 8'hF0;
  localparam logic [7:0] B_AA = 8'hAA;
  localparam logic [7:0] B_FA = 8'hFA;
  localparam logic [7:0] B_EE = 8'hEE;
  localparam logic [7:0] B_FC = 8'hFC;
  localparam logic [7:0] B_FF = 8'hFF;
  localparam logic [7:0] B_00 = 8'h00;
  localparam logic [7:0] PAUSE_CODE = 8'h77;
  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } evt_t;
endpackage

// File: rtl/ps2_evt_fifo.sv
// ps2_evt_fifo: event queue; a push into a full queue lands only when a pop frees a slot.
module ps2_evt_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  evt_t din,
  output evt_t dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  evt_t mem [DEPTH];
  logic do_pop, do_push;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  // Storage is never reset; the head is masked by the consumer while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: turns PS/2 set-2 scan-code bytes into queued make/break events.
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int PAUSE_SKIP = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  input  logic       evt_ready,
  input  logic       ovf_clr,
  output logic       evt_valid,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_break,
  output logic       overflow,
  output logic       kbd_err
);
  state_t state, state_n;
  logic [7:0] skip, skip_n;
  logic emit, err, full, empty, pop, drop;
  evt_t evt_n, head;
  wire is_err = byte_data == B_00 || byte_data == B_FC || byte_data == B_FF;
  wire is_ign = byte_data == B_AA || byte_data == B_FA || byte_data == B_EE;
  always_comb begin
    state_n = state;
    skip_n = skip;
    emit = 1'b0;
    err = 1'b0;
    evt_n = '{ext: 1'b0, brk: 1'b0, code: byte_data};
    if (byte_valid) begin
      if (is_err) begin
        state_n = IDLE;
        skip_n = '0;
        err = 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (byte_data == B_E0) state_n = EXT;
            else if (byte_data == B_F0) state_n = BRK;
            else if (byte_data == B_E1) begin
              state_n = PAUSE;
              skip_n = 8'(PAUSE_SKIP);
            end else emit = !is_ign;
          end
          EXT: begin
            state_n = byte_data == B_F0 ? EXT_BRK : IDLE;
            emit = byte_data != B_F0;
            evt_n.ext = 1'b1;
          end
          BRK: begin
            state_n = IDLE;
            emit = 1'b1;
            evt_n.brk = 1'b1;
          end
          EXT_BRK: begin
            state_n = IDLE;
            emit = 1'b1;
            evt_n = '{ext: 1'b1, brk: 1'b1, code: byte_data};
          end
          PAUSE: begin
            skip_n = skip == '0 ? '0 : skip - 8'd1;
            emit = skip <= 8'd1;
            state_n = emit ? IDLE : PAUSE;
            evt_n = '{ext: 1'b1, brk: 1'b0, code: PAUSE_CODE};
          end
          default: state_n = IDLE;
        endcase
      end
    end
  end
  assign evt_valid = !empty;
  assign pop = evt_ready && evt_valid;
  assign drop = emit && full && !pop;
  assign evt_code = evt_valid ? head.code : 8'h00;
  assign evt_ext = evt_valid && head.ext;
  assign evt_break = evt_valid && head.brk;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      skip <= '0;
      overflow <= 1'b0;
      kbd_err <= 1'b0;
    end else begin
      state <= state_n;
      skip <= skip_n;
      overflow <= drop ? 1'b1 : ovf_clr ? 1'b0 : overflow;
      kbd_err <= err;
    end
  end
  ps2_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(emit),
    .pop(pop),
    .din(evt_n),
    .dout(head),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb_ps2_scancode_decoder: directed and random byte streams against a queue-based reference model.
module tb_ps2_scancode_decoder;
  localparam int DEPTH = 4;
  localparam int SKIP = 7;
  logic clk = 1'b0, rst_n = 1'b0;
  logic byte_valid = 1'b0, evt_ready = 1'b0, ovf_clr = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic evt_valid, evt_ext, evt_break, overflow, kbd_err;
  logic [7:0] evt_code;
  int checks = 0, errors = 0;
  logic [9:0] q [$];
  bit m_ext, m_brk, m_ovf, m_err;
  int m_pause;
  ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH), .PAUSE_SKIP(SKIP)) dut (
    .clk(clk), .rst_n(rst_n), .byte_valid(byte_valid), .byte_data(byte_data),
    .evt_ready(evt_ready), .ovf_clr(ovf_clr), .evt_valid(evt_valid),
    .evt_code(evt_code), .evt_ext(evt_ext), .evt_break(evt_break),
    .overflow(overflow), .kbd_err(kbd_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  function automatic void model_clear();
    q.delete();
    m_ext = 0; m_brk = 0; m_ovf = 0; m_err = 0; m_pause = 0;
  endfunction
  task automatic compare();
    check("evt_valid", 32'(evt_valid), 32'(q.size() > 0));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("kbd_err", 32'(kbd_err), 32'(m_err));
    if (q.size() > 0) check("event", {22'd0, evt_ext, evt_break, evt_code}, {22'd0, q[0]});
  endtask
  // One clock: drive inputs, advance the model, compare at the next falling edge.
  task automatic step(input bit bv, input logic [7:0] bd, input bit rdy, input bit clr);
    bit push, pop;
    logic [9:0] ev;
    byte_valid = bv; byte_data = bd; evt_ready = rdy; ovf_clr = clr;
    push = 0;
    ev = {2'b00, bd};
    m_err = bv && (bd == 8'h00 || bd == 8'hFC || bd == 8'hFF);
    if (bv) begin
      if (m_err) begin
        m_ext = 0; m_brk = 0; m_pause = 0;
      end else if (m_pause > 0) begin
        m_pause--;
        if (m_pause == 0) begin push = 1; ev = {2'b10, 8'h77}; end
      end else if (m_brk) begin
        push = 1; ev = {m_ext, 1'b1, bd}; m_ext = 0; m_brk = 0;
      end else if (bd == 8'hF0) m_brk = 1;
      else if (m_ext) begin
        push = 1; ev = {2'b10, bd}; m_ext = 0;
      end else if (bd == 8'hE0) m_ext = 1;
      else if (bd == 8'hE1) m_pause = SKIP;
      else if (!(bd == 8'hAA || bd == 8'hFA || bd == 8'hEE)) push = 1;
    end
    pop = rdy && q.size() > 0;
    if (push && q.size() == DEPTH && !pop) m_ovf = 1;
    else if (clr) m_ovf = 0;
    if (pop) void'(q.pop_front());
    if (push && q.size() < DEPTH) q.push_back(ev);
    @(negedge clk);
    compare();
  endtask
  task automatic reset_pulse();
    byte_valid = 0; evt_ready = 0; ovf_clr = 0;
    rst_n = 0;
    #2;
    model_clear();
    check("rst_valid", 32'(evt_valid), 0);
    check("rst_code", 32'(evt_code), 0);
    check("rst_flags", {evt_ext, evt_break, overflow, kbd_err}, 0);
    @(negedge clk);
    rst_n = 1;
  endtask
  task automatic bytes(input logic [7:0] b [$], input bit rdy);
    foreach (b[i]) step(1, b[i], rdy, 0);
  endtask
  initial begin
    logic [7:0] pick [12] = '{8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'hFA, 8'hEE,
                              8'hFC, 8'hFF, 8'h00, 8'h1C, 8'h77, 8'h75};
    @(negedge clk);
    reset_pulse();
    bytes('{8'h1C, 8'hF0, 8'h1C}, 1);
    step(0, 8'h00, 1, 0);
    bytes('{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75}, 1);
    step(0, 8'h00, 1, 0);
    bytes('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77}, 0);
    check("pause_count", 32'(q.size()), 1);
    step(0, 8'h00, 1, 0);
    bytes('{8'h11, 8'h22, 8'h33, 8'h44, 8'h55}, 0);
    step(0, 8'h00, 0, 1);
    step(1, 8'h66, 1, 0);
    step(0, 8'h00, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 8'h00, 1, 0);
    step(1, 8'hE0, 0, 0);
    reset_pulse();
    step(1, 8'h1C, 1, 0);
    bytes('{8'hF0, 8'hFC, 8'h2A}, 1);
    step(1, 8'hE1, 1, 0);
    reset_pulse();
    bytes('{8'h3B, 8'hAA}, 1);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) reset_pulse();
      else step($urandom_range(0, 1), $urandom_range(0, 2) == 0 ? 8'($urandom) : pick[$urandom_range(0, 11)],
                $urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
